// File: rtl/raster_ctrl_pkg.sv
// rtl/raster_ctrl_pkg.sv - shared types and defaults for the raster frame controller
package raster_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    DRAW,
    DRAIN,
    SWAP
  } frame_seq_state_t;

  localparam int DEFAULT_MAX_INFLIGHT = 16;
  localparam int DEFAULT_TIMEOUT_CYC  = 65536;

endpackage

// File: rtl/inflight_counter.sv
// rtl/inflight_counter.sv - saturating up/down triangle credit counter
module inflight_counter #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         ovf_o,
  output logic         unf_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;

  // Error strobes fire only when the move would leave the legal range.
  assign ovf_o   = inc_i && !dec_i && (count_q == MAX_V);
  assign unf_o   = dec_i && !inc_i && (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && !dec_i && !ovf_o) begin
      count_q <= count_q + 1'b1;
    end else if (dec_i && !inc_i && !unf_o) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame start, drain detection and buffer swap control
module frame_sequencer
  import raster_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1),
  parameter int TIMEOUT_CYC  = DEFAULT_TIMEOUT_CYC,
  parameter int FRAME_CNT_W  = 16,
  parameter int MISS_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   initial_load_done,
  input  logic                   vsync,
  input  logic                   draw_done,
  input  logic                   tri_in_fire,
  input  logic                   tri_out_fire,
  input  logic                   err_clr,
  output logic                   frame_start,
  output logic                   issue_ok,
  output logic                   buf_swap,
  output logic                   front_buf,
  output logic                   busy,
  output logic [CNT_W-1:0]       inflight,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [MISS_W-1:0]      missed_vsync,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   err_timeout
);

  localparam int               WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_INFLIGHT);

  frame_seq_state_t       state_q;
  logic                   frame_start_q;
  logic                   front_buf_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [MISS_W-1:0]      missed_q;
  logic [WD_W-1:0]        wd_q;
  logic                   err_overflow_q, err_underflow_q, err_timeout_q;
  logic                   ovf_d, unf_d, drained_d, wd_expire_d, vsync_missed_d;

  assign drained_d      = (inflight == '0);
  assign wd_expire_d    = (state_q == DRAIN) && !drained_d && (wd_q == WD_LAST);
  assign vsync_missed_d = vsync && (state_q == DRAW || state_q == DRAIN || state_q == SWAP);

  // A watchdog expiry discards the stuck credits so the next frame starts clean.
  inflight_counter #(
    .MAX (MAX_INFLIGHT),
    .W   (CNT_W)
  ) u_inflight (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (tri_in_fire),
    .dec_i   (tri_out_fire),
    .clr_i   (wd_expire_d),
    .count_o (inflight),
    .ovf_o   (ovf_d),
    .unf_o   (unf_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      frame_start_q   <= 1'b0;
      front_buf_q     <= 1'b0;
      frame_count_q   <= '0;
      missed_q        <= '0;
      wd_q            <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      frame_start_q   <= 1'b0;
      err_overflow_q  <= (err_overflow_q  && !err_clr) || ovf_d;
      err_underflow_q <= (err_underflow_q && !err_clr) || unf_d;
      err_timeout_q   <= (err_timeout_q   && !err_clr) || wd_expire_d;
      if (vsync_missed_d && (missed_q != '1)) begin
        missed_q <= missed_q + 1'b1;
      end
      case (state_q)
        IDLE:       if (initial_load_done) state_q <= WAIT_VSYNC;
        WAIT_VSYNC: if (vsync) begin
                      state_q       <= DRAW;
                      frame_start_q <= 1'b1;
                    end
        DRAW:       if (draw_done) begin
                      state_q <= DRAIN;
                      wd_q    <= '0;
                    end
        // Swap side effects land on entry so they are visible alongside buf_swap.
        DRAIN:      if (drained_d || wd_expire_d) begin
                      state_q       <= SWAP;
                      front_buf_q   <= ~front_buf_q;
                      frame_count_q <= frame_count_q + 1'b1;
                    end else begin
                      wd_q <= wd_q + 1'b1;
                    end
        SWAP:       state_q <= initial_load_done ? WAIT_VSYNC : IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign frame_start   = frame_start_q;
  assign issue_ok      = (state_q == DRAW) && (inflight < MAX_V);
  assign buf_swap      = (state_q == SWAP);
  assign front_buf     = front_buf_q;
  assign busy          = (state_q == DRAW) || (state_q == DRAIN);
  assign frame_count   = frame_count_q;
  assign missed_vsync  = missed_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer
module tb_frame_sequencer;

  localparam int MAXI = 4;
  localparam int TMO  = 100;
  localparam int S_IDLE = 0, S_WAIT = 1, S_DRAW = 2, S_DRAIN = 3, S_SWAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld = 1'b0, vs = 1'b0, dd = 1'b0, tin = 1'b0, tout = 1'b0, eclr = 1'b0;
  logic        frame_start, issue_ok, buf_swap, front_buf, busy;
  logic [2:0]  inflight;
  logic [15:0] frame_count;
  logic [7:0]  missed_vsync;
  logic        err_overflow, err_underflow, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int m_state, m_infl, m_fc, m_miss, m_drain;
  bit m_fs, m_front, m_eo, m_eu, m_et;

  frame_sequencer #(.MAX_INFLIGHT(MAXI), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .initial_load_done(ld), .vsync(vs), .draw_done(dd),
    .tri_in_fire(tin), .tri_out_fire(tout), .err_clr(eclr),
    .frame_start(frame_start), .issue_ok(issue_ok), .buf_swap(buf_swap),
    .front_buf(front_buf), .busy(busy), .inflight(inflight),
    .frame_count(frame_count), .missed_vsync(missed_vsync),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_infl = 0; m_fc = 0; m_miss = 0; m_drain = 0;
    m_fs = 0; m_front = 0; m_eo = 0; m_eu = 0; m_et = 0;
  endtask

  // One clock of the frame rules, applied to the inputs present at the edge.
  task automatic model_step();
    int  ns;
    bit  ovf, unf, tmo;
    ovf = tin && !tout && (m_infl == MAXI);
    unf = tout && !tin && (m_infl == 0);
    tmo = 0;
    ns  = m_state;
    case (m_state)
      S_IDLE:  if (ld) ns = S_WAIT;
      S_WAIT:  if (vs) ns = S_DRAW;
      S_DRAW:  if (dd) begin ns = S_DRAIN; m_drain = 0; end
      S_DRAIN: begin
        m_drain++;
        if (m_infl == 0) ns = S_SWAP;
        else if (m_drain == TMO) begin tmo = 1; ns = S_SWAP; end
      end
      default: ns = ld ? S_WAIT : S_IDLE;
    endcase
    if (vs && m_state >= S_DRAW && m_miss < 255) m_miss++;
    m_fs = (m_state == S_WAIT) && vs;
    if (ns == S_SWAP && m_state != S_SWAP) begin
      m_front = !m_front;
      m_fc    = (m_fc + 1) % 65536;
    end
    if (tmo) m_infl = 0;
    else if (tin && !tout) m_infl = (m_infl < MAXI) ? m_infl + 1 : MAXI;
    else if (tout && !tin) m_infl = (m_infl > 0) ? m_infl - 1 : 0;
    m_eo = (m_eo && !eclr) || ovf;
    m_eu = (m_eu && !eclr) || unf;
    m_et = (m_et && !eclr) || tmo;
    m_state = ns;
  endtask

  task automatic check_all();
    check("frame_start", frame_start, m_fs);
    check("issue_ok", issue_ok, (m_state == S_DRAW) && (m_infl < MAXI));
    check("buf_swap", buf_swap, m_state == S_SWAP);
    check("front_buf", front_buf, m_front);
    check("busy", busy, (m_state == S_DRAW) || (m_state == S_DRAIN));
    check("inflight", inflight, m_infl);
    check("frame_count", frame_count, m_fc);
    check("missed_vsync", missed_vsync, m_miss);
    check("err_overflow", err_overflow, m_eo);
    check("err_underflow", err_underflow, m_eu);
    check("err_timeout", err_timeout, m_et);
  endtask

  task automatic cyc(input bit i_in, input bit i_out, input bit i_vs,
                     input bit i_dd, input bit i_clr);
    tin = i_in; tout = i_out; vs = i_vs; dd = i_dd; eclr = i_clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b1;
    ld  = 1'b1;

    // Frame start latency: vsync on the 10th cycle after reset release.
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("t1_frame_start", frame_start, 1);
    check("t1_busy", busy, 1);
    check("t1_issue_ok", issue_ok, 1);
    cyc(0, 0, 0, 0, 0);
    check("t1_frame_start_pulse", frame_start, 0);

    // Credit limit and overflow.
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i == 4) check("t2_issue_ok_at_max", issue_ok, 0);
    end
    check("t2_inflight_sat", inflight, MAXI);
    check("t2_err_overflow", err_overflow, 1);
    cyc(0, 0, 0, 0, 1);
    check("t2_err_clr", err_overflow, 0);
    for (int i = 0; i < MAXI; i++) cyc(0, 1, 0, 0, 0);

    // Drain then swap.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("t3_busy_drain", busy, 1);
    end
    for (k = 0; k < 10; k++) begin
      if (buf_swap) break;
      cyc(0, 0, 0, 0, 0);
    end
    check("t3_swap_seen", buf_swap, 1);
    check("t3_front_buf", front_buf, 1);
    check("t3_frame_count", frame_count, 1);
    cyc(0, 0, 0, 0, 0);
    check("t3_swap_one_cycle", buf_swap, 0);

    // Simultaneous fires and underflow.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("t4_both_fire", inflight, 2);
    check("t4_no_err", {err_overflow, err_underflow}, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("t4_err_underflow", err_underflow, 1);
    check("t4_inflight_zero", inflight, 0);
    cyc(0, 0, 0, 0, 1);

    // Drain watchdog.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (k = 0; k < 150; k++) begin
      if (buf_swap) break;
      cyc(0, 0, 0, 0, 0);
    end
    check("t5_drain_cycles", k, TMO);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_inflight_forced", inflight, 0);
    cyc(0, 0, 0, 0, 1);

    // Missed vsyncs, then reset mid-drain.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("t6_missed_vsync", missed_vsync, 2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("t6_in_drain", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_inflight", inflight, 0);
    check("t6_rst_missed", missed_vsync, 0);
    check("t6_rst_frame_count", frame_count, 0);
    check("t6_rst_front_buf", front_buf, 0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r_in;
      if ($urandom_range(0, 149) == 0) ld = !ld;
      if ($urandom_range(0, 699) == 0) begin
        async_reset();
      end else begin
        r_in = (m_state == S_DRAW && m_infl < MAXI) ? ($urandom_range(0, 1) == 1)
                                                    : ($urandom_range(0, 15) == 0);
        cyc(r_in, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
